effect_param_sched: RTL and testbench
=====================================

// Module: effect_param_sched
// PURPOSE
//  Scheduler that applies UART effect-chain commands (echo..remote filter, 240-bit frame) to the live chain without clicks.
//  Captures each new command into a pending register and ramps the chain output gain to zero, one step per sample strobe.
//  At zero gain it commits pending->active and holds mute for HOLD_SAMPLES samples, then ramps back to unity.
//  Sits between uart_cmd and the effect instances; gain_out drives the post-chain multiplier: out = (s*gain_out)>>>8.
// PARAMETERS
//  CMD_W         240  command frame width
//  GAIN_STEP     16   gain change per sample_strobe (unity = 256; 16 samples per ramp at default)
//  HOLD_SAMPLES  8    muted samples after commit, to flush effect delay lines; valid range 1..255
// PORTS
//  clk           in   1      system clock (single clock domain)
//  reset         in   1      synchronous, active-high reset
//  cmd_data      in   CMD_W  command frame from UART receiver
//  cmd_valid     in   1      1-cycle pulse; cmd_data is valid in that cycle
//  sample_strobe in   1      1-cycle pulse per stereo sample (DAC FIFO write)
//  active_cmd    out  CMD_W  committed command driving all effect parameter ports
//  gain_out      out  9      output gain, 0..256, unsigned Q1.8
//  commit_pulse  out  1      1-cycle pulse in the cycle after active_cmd updates
//  busy          out  1      high whenever state != IDLE
//  drop_cnt      out  8      saturating count of pending commands overwritten before commit
// BEHAVIOUR
//  Reset (sync, next clk edge, any state)
//   - active_cmd=0 (all en nibbles 0 = every effect bypassed); pending=0; pend_flag=0.
//   - gain_out=256; state=IDLE; commit_pulse=0; busy=0; drop_cnt=0; hold counter=0.
//  Capture (every state)
//   - On cmd_valid: pending<=cmd_data; pend_flag<=1.
//   - If pend_flag was already 1: drop_cnt++ (saturates at 255).
//   - A capture overrides a same-cycle clear of pend_flag.
//  States
//   - IDLE: each cycle with pend_flag=1:
//     - pending==active_cmd: clear pend_flag, stay in IDLE, gain unchanged.
//     - otherwise -> FADE_OUT (next cycle).
//     - The comparison uses the registered pending, so a cmd_valid cycle is evaluated one cycle later.
//   - FADE_OUT: on sample_strobe, gain <= (gain<=GAIN_STEP) ? 0 : gain-GAIN_STEP.
//     - The cycle after gain reaches 0 -> COMMIT.
//   - COMMIT: single cycle.
//     - active_cmd<=pending; pend_flag<=0 unless cmd_valid this cycle; hold counter<=HOLD_SAMPLES.
//     - -> HOLD; commit_pulse=1 in the following cycle.
//   - HOLD: gain stays 0; hold counter decrements on each sample_strobe.
//     - At 0 with pend_flag=1 and pending!=active_cmd -> COMMIT (no fade needed, gain already 0).
//     - At 0 otherwise -> FADE_IN (stale equal pending is cleared).
//   - FADE_IN: on sample_strobe, gain <= min(gain+GAIN_STEP, 256).
//     - The cycle after gain reaches 256 -> IDLE.
//     - If pend_flag=1 and pending!=active_cmd -> FADE_OUT next cycle; the ramp continues down from the current gain.
//  Timing and arithmetic
//   - gain changes only on sample_strobe cycles, and by exactly GAIN_STEP except at the 0/256 clamp.
//   - active_cmd changes only in COMMIT, so effects always see a whole frame, never mixed fields.
//   - sample_strobe and cmd_valid in the same cycle: both take effect independently.
//   - No sample_strobe: the FSM stalls in its ramp/hold state indefinitely; there is no timeout.
// TESTING
//  T1 reset: assert reset 1 cycle mid-FADE_OUT -> active_cmd=0, gain_out=256, busy=0, drop_cnt=0 next cycle.
//  T2 single cmd (0xA55 in [239:228]), strobe every 4 clk.
//     - gain 256,240,..,0 over 16 strobes; commit_pulse once.
//     - active_cmd[239:228]=0xA55; 8 strobes at 0; ramp back to 256; busy drops.
//  T3 cmd equal to active_cmd while IDLE -> no gain change, no commit_pulse, busy stays 0.
//  T4 two cmds 2 cycles apart during FADE_OUT -> drop_cnt=1; only the second frame is committed; exactly one commit_pulse.
//  T5 new differing cmd when FADE_IN gain=128 -> next strobe gain=112, down to 0, second commit.
//  T6 cmd_valid coincident with COMMIT cycle -> pend_flag stays 1; after hold a second commit occurs with gain still 0.

Source files
------------

// File: rtl/effect_param_sched.sv
// Click-free effect-chain parameter scheduler: fades the post-chain gain to zero,
// swaps in the pending command frame, holds mute to flush delay lines, then fades back up.
module effect_param_sched #(
    parameter int unsigned CMD_W        = 240,
    parameter int unsigned GAIN_STEP    = 16,
    parameter int unsigned HOLD_SAMPLES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CMD_W-1:0] cmd_data,
    input  logic             cmd_valid,
    input  logic             sample_strobe,
    output logic [CMD_W-1:0] active_cmd,
    output logic [8:0]       gain_out,
    output logic             commit_pulse,
    output logic             busy,
    output logic [7:0]       drop_cnt
);

    localparam logic [8:0] UNITY = 9'd256;
    localparam logic [8:0] STEP  = 9'(GAIN_STEP);
    localparam logic [7:0] HOLD  = 8'(HOLD_SAMPLES);

    typedef enum logic [2:0] {
        IDLE,
        FADE_OUT,
        COMMIT,
        HOLD_MUTE,
        FADE_IN
    } state_t;

    state_t             state, state_next;
    logic [CMD_W-1:0]   pending;
    logic               pend_flag;
    logic               clr_pend;
    logic               differ;
    logic [7:0]         hold_cnt;
    logic [8:0]         gain_next;

    assign differ = (pending != active_cmd);
    assign busy   = (state != IDLE);

    always_comb begin
        state_next = state;
        clr_pend   = 1'b0;
        case (state)
            IDLE: begin
                if (pend_flag) begin
                    if (differ) state_next = FADE_OUT;
                    else        clr_pend   = 1'b1;
                end
            end
            FADE_OUT: begin
                if (gain_out == '0) state_next = COMMIT;
            end
            COMMIT: begin
                state_next = HOLD_MUTE;
                clr_pend   = 1'b1;
            end
            HOLD_MUTE: begin
                if (hold_cnt == '0) begin
                    if (pend_flag && differ) begin
                        state_next = COMMIT;
                    end else begin
                        state_next = FADE_IN;
                        clr_pend   = 1'b1;
                    end
                end
            end
            FADE_IN: begin
                // a differing command reverses the ramp from wherever the gain is now
                if (pend_flag && differ)  state_next = FADE_OUT;
                else if (gain_out == UNITY) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        gain_next = gain_out;
        if (sample_strobe) begin
            if (state == FADE_OUT) begin
                gain_next = (gain_out <= STEP) ? 9'd0 : gain_out - STEP;
            end else if (state == FADE_IN) begin
                gain_next = (gain_out >= UNITY - STEP) ? UNITY : gain_out + STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            active_cmd   <= '0;
            pending      <= '0;
            pend_flag    <= 1'b0;
            gain_out     <= UNITY;
            commit_pulse <= 1'b0;
            drop_cnt     <= '0;
            hold_cnt     <= '0;
        end else begin
            state        <= state_next;
            gain_out     <= gain_next;
            commit_pulse <= (state == COMMIT);

            if (state == COMMIT) begin
                active_cmd <= pending;
                hold_cnt   <= HOLD;
            end else if (state == HOLD_MUTE && sample_strobe && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 8'd1;
            end

            // capture wins over any same-cycle clear of the pending flag
            if (cmd_valid) begin
                pending   <= cmd_data;
                pend_flag <= 1'b1;
                if (pend_flag && drop_cnt != '1) drop_cnt <= drop_cnt + 8'd1;
            end else if (clr_pend) begin
                pend_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_effect_param_sched.sv
// Self-checking bench for effect_param_sched: directed ramp/commit scenarios plus
// randomized command/strobe traffic checked against gain/commit invariants and final state.
module tb_effect_param_sched;

    localparam int CMD_W = 240;

    logic             clk = 1'b0;
    logic             reset;
    logic [CMD_W-1:0] cmd_data;
    logic             cmd_valid;
    logic             sample_strobe;
    logic [CMD_W-1:0] active_cmd;
    logic [8:0]       gain_out;
    logic             commit_pulse;
    logic             busy;
    logic [7:0]       drop_cnt;

    int errors = 0;
    int checks = 0;
    int pulse_cnt = 0;
    bit mon_en = 1'b0;
    logic             strobe_q;
    int               prev_gain;
    logic [CMD_W-1:0] prev_active;

    always #5 clk = ~clk;

    effect_param_sched #(
        .CMD_W(240),
        .GAIN_STEP(16),
        .HOLD_SAMPLES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_data(cmd_data),
        .cmd_valid(cmd_valid),
        .sample_strobe(sample_strobe),
        .active_cmd(active_cmd),
        .gain_out(gain_out),
        .commit_pulse(commit_pulse),
        .busy(busy),
        .drop_cnt(drop_cnt)
    );

    always @(posedge clk) strobe_q <= sample_strobe;

    // Invariant monitor: gain moves only after a strobe, by one step or to a clamp;
    // active_cmd only changes while muted, and the commit pulse accompanies the change.
    always @(negedge clk) begin
        int g;
        g = int'(gain_out);
        if (commit_pulse) pulse_cnt++;
        if (mon_en) begin
            if (g != prev_gain) begin
                checks++;
                if (!strobe_q || !(g == prev_gain - 16 || g == prev_gain + 16 ||
                                   (g == 0 && prev_gain < 16) || (g == 256 && prev_gain > 240))) begin
                    errors++;
                    $display("FAIL mon_gain_step: prev=%0d now=%0d strobe=%0b", prev_gain, g, strobe_q);
                end
            end
            if (active_cmd !== prev_active) begin
                checks++;
                if (!(g == 0 && commit_pulse === 1'b1)) begin
                    errors++;
                    $display("FAIL mon_commit: gain=%0d commit_pulse=%0b (required gain=0 pulse=1)", g, commit_pulse);
                end
            end
        end
        prev_gain   = g;
        prev_active = active_cmd;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic step(input logic v, input logic [CMD_W-1:0] d, input logic s);
        cmd_valid     = v;
        cmd_data      = d;
        sample_strobe = s;
        @(posedge clk);
        #1;
        cmd_valid     = 1'b0;
        sample_strobe = 1'b0;
    endtask

    task automatic strobe4();
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
    endtask

    function automatic logic [CMD_W-1:0] rnd_cmd();
        logic [CMD_W-1:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = {r[CMD_W-33:0], $urandom()};
        return r;
    endfunction

    task automatic run_to_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 100) begin
            strobe4();
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s_timeout: busy=%0b after %0d strobes (required 0)", name, busy, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        reset = 1'b0;
        checks += 5;
        if (active_cmd !== '0)   begin errors++; $display("FAIL reset_active: got %h required 0", active_cmd); end
        if (gain_out !== 9'd256) begin errors++; $display("FAIL reset_gain: got %0d required 256", gain_out); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %0b required 0", busy); end
        if (drop_cnt !== 8'd0)   begin errors++; $display("FAIL reset_drop: got %0d required 0", drop_cnt); end
        if (commit_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %0b required 0", commit_pulse); end
    endtask

    task automatic test_single_cmd();
        logic [CMD_W-1:0] x;
        logic [11:0]      top;
        int p0;
        x = '0;
        x[239:228] = 12'hA55;
        p0 = pulse_cnt;
        step(1'b1, x, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            strobe4();
            checks++;
            if (int'(gain_out) != 256 - 16 * k) begin
                errors++;
                $display("FAIL single_fade_out: strobe %0d gain=%0d required %0d", k, gain_out, 256 - 16 * k);
            end
        end
        checks += 2;
        if (busy !== 1'b1)     begin errors++; $display("FAIL single_busy: got %0b required 1", busy); end
        if (active_cmd !== '0) begin errors++; $display("FAIL single_early_commit: active=%h required 0", active_cmd); end
        for (int k = 1; k <= 8; k++) begin
            strobe4();
            checks++;
            if (gain_out !== 9'd0) begin
                errors++;
                $display("FAIL single_hold: hold strobe %0d gain=%0d required 0", k, gain_out);
            end
            if (k == 1) begin
                top = active_cmd[239:228];
                checks++;
                if (top !== 12'hA55 || active_cmd !== x) begin
                    errors++;
                    $display("FAIL single_commit: active[239:228]=%h required a55", top);
                end
            end
        end
        for (int k = 1; k <= 16; k++) begin
            strobe4();
            checks++;
            if (int'(gain_out) != 16 * k) begin
                errors++;
                $display("FAIL single_fade_in: strobe %0d gain=%0d required %0d", k, gain_out, 16 * k);
            end
        end
        step(1'b0, '0, 1'b0);
        checks += 2;
        if (busy !== 1'b0)        begin errors++; $display("FAIL single_idle: busy=%0b required 0", busy); end
        if (pulse_cnt - p0 != 1)  begin errors++; $display("FAIL single_pulses: got %0d required 1", pulse_cnt - p0); end
    endtask

    task automatic test_equal_cmd();
        int p0;
        logic [CMD_W-1:0] x;
        x = active_cmd;
        p0 = pulse_cnt;
        step(1'b1, x, 1'b0);
        for (int k = 0; k < 3; k++) begin
            strobe4();
            checks += 2;
            if (gain_out !== 9'd256) begin errors++; $display("FAIL equal_gain: gain=%0d required 256", gain_out); end
            if (busy !== 1'b0)       begin errors++; $display("FAIL equal_busy: busy=%0b required 0", busy); end
        end
        checks += 2;
        if (pulse_cnt != p0)   begin errors++; $display("FAIL equal_pulses: got %0d required 0", pulse_cnt - p0); end
        if (drop_cnt !== 8'd0) begin errors++; $display("FAIL equal_drop: got %0d required 0", drop_cnt); end
    endtask

    task automatic test_drop();
        logic [CMD_W-1:0] y, z;
        int p0;
        y = rnd_cmd(); y[239:228] = 12'h111;
        z = rnd_cmd(); z[239:228] = 12'h222;
        p0 = pulse_cnt;
        step(1'b1, y, 1'b0);
        step(1'b0, '0, 1'b0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL drop_fading: busy=%0b required 1", busy); end
        step(1'b1, z, 1'b0);
        checks++;
        if (drop_cnt !== 8'd1) begin errors++; $display("FAIL drop_count: got %0d required 1", drop_cnt); end
        run_to_idle("drop");
        checks += 3;
        if (active_cmd !== z)    begin errors++; $display("FAIL drop_active: top=%h required 222", active_cmd[239:228]); end
        if (pulse_cnt - p0 != 1) begin errors++; $display("FAIL drop_pulses: got %0d required 1", pulse_cnt - p0); end
        if (drop_cnt !== 8'd1)   begin errors++; $display("FAIL drop_final: got %0d required 1", drop_cnt); end
    endtask

    task automatic test_retarget();
        logic [CMD_W-1:0] p, q;
        int p0, n;
        p = rnd_cmd(); p[239:228] = 12'h333;
        q = rnd_cmd(); q[239:228] = 12'h444;
        p0 = pulse_cnt;
        step(1'b1, p, 1'b0);
        n = 0;
        while (active_cmd !== p && n < 60) begin strobe4(); n++; end
        while (gain_out !== 9'd128 && n < 120) begin strobe4(); n++; end
        checks++;
        if (gain_out !== 9'd128 || active_cmd !== p) begin
            errors++;
            $display("FAIL retarget_reach: gain=%0d required 128 in fade-in", gain_out);
        end
        step(1'b1, q, 1'b0);
        strobe4();
        checks++;
        if (gain_out !== 9'd112) begin errors++; $display("FAIL retarget_reverse: gain=%0d required 112", gain_out); end
        run_to_idle("retarget");
        checks += 2;
        if (active_cmd !== q)    begin errors++; $display("FAIL retarget_active: top=%h required 444", active_cmd[239:228]); end
        if (pulse_cnt - p0 != 2) begin errors++; $display("FAIL retarget_pulses: got %0d required 2", pulse_cnt - p0); end
    endtask

    task automatic test_commit_collide();
        logic [CMD_W-1:0] r, s;
        int p0, n;
        r = rnd_cmd(); r[239:228] = 12'h555;
        s = rnd_cmd(); s[239:228] = 12'h666;
        p0 = pulse_cnt;
        step(1'b1, r, 1'b0);
        n = 0;
        while (gain_out !== 9'd0 && n < 40) begin strobe4(); n++; end
        step(1'b0, '0, 1'b0);
        step(1'b1, s, 1'b0);
        checks += 2;
        if (active_cmd !== r)      begin errors++; $display("FAIL collide_first: top=%h required 555", active_cmd[239:228]); end
        if (commit_pulse !== 1'b1) begin errors++; $display("FAIL collide_pulse: got %0b required 1", commit_pulse); end
        n = 0;
        while (active_cmd !== s && n < 20) begin
            strobe4();
            n++;
            checks++;
            if (gain_out !== 9'd0) begin errors++; $display("FAIL collide_mute: gain=%0d required 0", gain_out); end
        end
        checks += 2;
        if (active_cmd !== s) begin errors++; $display("FAIL collide_second: top=%h required 666", active_cmd[239:228]); end
        if (n != 9)           begin errors++; $display("FAIL collide_hold_len: strobe calls=%0d required 9", n); end
        run_to_idle("collide");
        checks += 2;
        if (pulse_cnt - p0 != 2) begin errors++; $display("FAIL collide_pulses: got %0d required 2", pulse_cnt - p0); end
        if (gain_out !== 9'd256) begin errors++; $display("FAIL collide_unity: gain=%0d required 256", gain_out); end
    endtask

    task automatic test_random();
        logic [CMD_W-1:0] pool [4];
        logic [CMD_W-1:0] last, d;
        logic v, s;
        int n;
        for (int i = 0; i < 4; i++) pool[i] = rnd_cmd();
        last = active_cmd;
        mon_en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            v = ($urandom_range(0, 59) == 0);
            s = ($urandom_range(0, 2) == 0);
            d = pool[$urandom_range(0, 3)];
            if (v) last = d;
            step(v, d, s);
        end
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        n = 0;
        while (busy && n < 2000) begin
            step(1'b0, '0, (n % 3) == 0);
            n++;
        end
        mon_en = 1'b0;
        checks += 3;
        if (busy !== 1'b0)       begin errors++; $display("FAIL random_settle: busy=%0b required 0", busy); end
        if (active_cmd !== last) begin errors++; $display("FAIL random_active: top=%h required %h", active_cmd[239:228], last[239:228]); end
        if (gain_out !== 9'd256) begin errors++; $display("FAIL random_unity: gain=%0d required 256", gain_out); end
    endtask

    task automatic test_reset_mid_fade();
        logic [CMD_W-1:0] t;
        t = rnd_cmd(); t[239:228] = 12'h777;
        step(1'b1, t, 1'b0);
        strobe4();
        step(1'b1, rnd_cmd(), 1'b0);
        strobe4();
        strobe4();
        checks++;
        if (gain_out !== 9'd208) begin errors++; $display("FAIL midreset_pre: gain=%0d required 208", gain_out); end
        reset = 1'b1;
        step(1'b0, '0, 1'b0);
        reset = 1'b0;
        checks += 5;
        if (active_cmd !== '0)     begin errors++; $display("FAIL midreset_active: top=%h required 0", active_cmd[239:228]); end
        if (gain_out !== 9'd256)   begin errors++; $display("FAIL midreset_gain: got %0d required 256", gain_out); end
        if (busy !== 1'b0)         begin errors++; $display("FAIL midreset_busy: got %0b required 0", busy); end
        if (drop_cnt !== 8'd0)     begin errors++; $display("FAIL midreset_drop: got %0d required 0", drop_cnt); end
        if (commit_pulse !== 1'b0) begin errors++; $display("FAIL midreset_pulse: got %0b required 0", commit_pulse); end
        strobe4();
        checks += 2;
        if (busy !== 1'b0)       begin errors++; $display("FAIL midreset_stay_idle: busy=%0b required 0", busy); end
        if (gain_out !== 9'd256) begin errors++; $display("FAIL midreset_stay_gain: got %0d required 256", gain_out); end
    endtask

    initial begin
        reset         = 1'b1;
        cmd_valid     = 1'b0;
        cmd_data      = '0;
        sample_strobe = 1'b0;
        test_reset();
        test_single_cmd();
        test_equal_cmd();
        test_drop();
        test_retarget();
        test_commit_collide();
        test_random();
        test_reset_mid_fade();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
